bf_stage_sdf: RTL and testbench

BF_STAGE_SDF -- requirements
Module: bf_stage_sdf

---
 rtl/bf_stage_sdf.sv | 125 ++++++++++++
 tb/tb_bf_stage_sdf.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_stage_sdf.sv
// Radix-2 single-path delay-feedback butterfly across NUM parallel lanes: first-half beats fill the delay buffer, second-half beats emit sum/difference pairs.
// Outputs are registered one cycle after each second-half beat; there is no backpressure, and the input may idle for any number of cycles.
module bf_stage_sdf #(
   parameter  int IN_WIDTH  = 9,
   parameter  int NUM       = 16,
   parameter  int DATA      = 512,
   parameter  int SCALE     = 0,
   localparam int COUNT     = DATA / NUM,
   localparam int HALF      = COUNT / 2,
   localparam int OUT_WIDTH = IN_WIDTH + ((SCALE != 0) ? 0 : 1),
   localparam int IW        = (HALF > 1) ? $clog2(HALF) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [IN_WIDTH-1:0]  din_i [NUM],
   input  logic signed [IN_WIDTH-1:0]  din_q [NUM],
   input  logic                        valid_in,
   input  logic                        sync_in,
   output logic signed [OUT_WIDTH-1:0] do1_re [NUM],
   output logic signed [OUT_WIDTH-1:0] do1_im [NUM],
   output logic signed [OUT_WIDTH-1:0] do2_re [NUM],
   output logic signed [OUT_WIDTH-1:0] do2_im [NUM],
   output logic                        valid_out,
   output logic [IW-1:0]               out_idx,
   output logic                        frame_done,
   output logic                        sat_flag
);

   localparam int CW = $clog2(COUNT);
   localparam int EW = IN_WIDTH + 2;
   localparam logic [CW-1:0]        HALF_C = CW'(HALF);
   localparam logic [CW-1:0]        LAST_C = CW'(COUNT - 1);
   localparam logic signed [EW-1:0] SMAX   = EW'((1 <<< (IN_WIDTH - 1)) - 1);
   localparam logic signed [EW-1:0] SMIN   = -SMAX - EW'(1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] idx;
   logic          sec_beat;
   logic [IW-1:0] wr_addr;
   logic [IW-1:0] rd_addr;

   logic signed [IN_WIDTH-1:0] buf_re [HALF][NUM];
   logic signed [IN_WIDTH-1:0] buf_im [HALF][NUM];

   logic [OUT_WIDTH:0] f1_re [NUM];
   logic [OUT_WIDTH:0] f1_im [NUM];
   logic [OUT_WIDTH:0] f2_re [NUM];
   logic [OUT_WIDTH:0] f2_im [NUM];
   logic [NUM-1:0]     lane_sat;

   // Result packed as {saturated, value}; full growth keeps the exact sum.
   function automatic logic [OUT_WIDTH:0] fit(input logic signed [EW-1:0] v);
      logic signed [EW-1:0] r;
      r = (v + EW'(1)) >>> 1;
      if (SCALE == 0)
         fit = {1'b0, v[OUT_WIDTH-1:0]};
      else if (r > SMAX)
         fit = {1'b1, SMAX[OUT_WIDTH-1:0]};
      else if (r < SMIN)
         fit = {1'b1, SMIN[OUT_WIDTH-1:0]};
      else
         fit = {1'b0, r[OUT_WIDTH-1:0]};
   endfunction

   // A sync beat restarts the frame, abandoning whatever was partly collected.
   assign idx      = (valid_in && sync_in) ? '0 : cnt;
   assign sec_beat = valid_in && (idx >= HALF_C);
   assign wr_addr  = IW'(idx);
   assign rd_addr  = IW'(idx - HALF_C);

   always_ff @(posedge clk) begin
      if (valid_in && !sec_beat) begin
         for (int l = 0; l < NUM; l++) begin
            buf_re[wr_addr][l] <= din_i[l];
            buf_im[wr_addr][l] <= din_q[l];
         end
      end
   end

   always_comb begin
      lane_sat = '0;
      for (int l = 0; l < NUM; l++) begin
         f1_re[l] = fit(EW'(buf_re[rd_addr][l]) + EW'(din_i[l]));
         f1_im[l] = fit(EW'(buf_im[rd_addr][l]) + EW'(din_q[l]));
         f2_re[l] = fit(EW'(buf_re[rd_addr][l]) - EW'(din_i[l]));
         f2_im[l] = fit(EW'(buf_im[rd_addr][l]) - EW'(din_q[l]));
         lane_sat[l] = f1_re[l][OUT_WIDTH] | f1_im[l][OUT_WIDTH] |
                       f2_re[l][OUT_WIDTH] | f2_im[l][OUT_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         sat_flag   <= 1'b0;
         out_idx    <= '0;
         for (int l = 0; l < NUM; l++) begin
            do1_re[l] <= '0;
            do1_im[l] <= '0;
            do2_re[l] <= '0;
            do2_im[l] <= '0;
         end
      end else begin
         valid_out  <= sec_beat;
         frame_done <= sec_beat && (idx == LAST_C);
         if (valid_in)
            cnt <= (idx == LAST_C) ? '0 : idx + 1'b1;
         if (sec_beat) begin
            out_idx <= rd_addr;
            for (int l = 0; l < NUM; l++) begin
               do1_re[l] <= f1_re[l][OUT_WIDTH-1:0];
               do1_im[l] <= f1_im[l][OUT_WIDTH-1:0];
               do2_re[l] <= f2_re[l][OUT_WIDTH-1:0];
               do2_im[l] <= f2_im[l][OUT_WIDTH-1:0];
            end
            // Sticky until reset; lane_sat never rises at full growth.
            if (|lane_sat)
               sat_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bf_stage_sdf.sv
// Bench for bf_stage_sdf: full-growth and halving instances share one randomized/directed stimulus stream.
module tb_bf_stage_sdf;
   localparam int IN_WIDTH = 9;
   localparam int NUM      = 2;
   localparam int DATA     = 8;
   localparam int COUNT    = DATA / NUM;
   localparam int HALF     = COUNT / 2;

   logic clk, rst, valid_in, sync_in;
   logic signed [IN_WIDTH-1:0] din_i [NUM];
   logic signed [IN_WIDTH-1:0] din_q [NUM];

   logic signed [IN_WIDTH:0]   f_do1_re [NUM], f_do1_im [NUM], f_do2_re [NUM], f_do2_im [NUM];
   logic signed [IN_WIDTH-1:0] h_do1_re [NUM], h_do1_im [NUM], h_do2_re [NUM], h_do2_im [NUM];
   logic       f_vld, h_vld, f_fd, h_fd, f_sat, h_sat;
   logic [0:0] f_idx, h_idx;

   bf_stage_sdf #(.IN_WIDTH(IN_WIDTH), .NUM(NUM), .DATA(DATA), .SCALE(0)) u_full (
      .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q),
      .valid_in(valid_in), .sync_in(sync_in),
      .do1_re(f_do1_re), .do1_im(f_do1_im), .do2_re(f_do2_re), .do2_im(f_do2_im),
      .valid_out(f_vld), .out_idx(f_idx), .frame_done(f_fd), .sat_flag(f_sat));

   bf_stage_sdf #(.IN_WIDTH(IN_WIDTH), .NUM(NUM), .DATA(DATA), .SCALE(1)) u_half (
      .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q),
      .valid_in(valid_in), .sync_in(sync_in),
      .do1_re(h_do1_re), .do1_im(h_do1_im), .do2_re(h_do2_re), .do2_im(h_do2_im),
      .valid_out(h_vld), .out_idx(h_idx), .frame_done(h_fd), .sat_flag(h_sat));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int vld_seen = 0;

   // Reference model: frame position, stored first-half samples, expected outputs.
   int pos;
   int m_re [HALF][NUM];
   int m_im [HALF][NUM];
   int e_vld, e_idx, e_fd, e_sat;
   int e_f1r [NUM], e_f1i [NUM], e_f2r [NUM], e_f2i [NUM];
   int e_h1r [NUM], e_h1i [NUM], e_h2r [NUM], e_h2i [NUM];

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int halve_sat(input int x);
      int h;
      h = int'($floor(real'(x + 1) / 2.0));
      if (h > 255) begin
         e_sat = 1;
         h = 255;
      end else if (h < -256) begin
         e_sat = 1;
         h = -256;
      end
      return h;
   endfunction

   task automatic model_step();
      int p, k, ar, ai, br, bi;
      if (rst) begin
         pos = 0; e_vld = 0; e_idx = 0; e_fd = 0; e_sat = 0;
         for (int l = 0; l < NUM; l++) begin
            e_f1r[l] = 0; e_f1i[l] = 0; e_f2r[l] = 0; e_f2i[l] = 0;
            e_h1r[l] = 0; e_h1i[l] = 0; e_h2r[l] = 0; e_h2i[l] = 0;
         end
      end else begin
         e_vld = 0;
         e_fd  = 0;
         if (valid_in) begin
            p = sync_in ? 0 : pos;
            if (p < HALF) begin
               for (int l = 0; l < NUM; l++) begin
                  m_re[p][l] = int'(din_i[l]);
                  m_im[p][l] = int'(din_q[l]);
               end
            end else begin
               k = p - HALF;
               for (int l = 0; l < NUM; l++) begin
                  ar = m_re[k][l]; ai = m_im[k][l];
                  br = int'(din_i[l]); bi = int'(din_q[l]);
                  e_f1r[l] = ar + br; e_f1i[l] = ai + bi;
                  e_f2r[l] = ar - br; e_f2i[l] = ai - bi;
                  e_h1r[l] = halve_sat(ar + br); e_h1i[l] = halve_sat(ai + bi);
                  e_h2r[l] = halve_sat(ar - br); e_h2i[l] = halve_sat(ai - bi);
               end
               e_vld = 1;
               e_idx = k;
               e_fd  = (k == HALF - 1) ? 1 : 0;
            end
            pos = (p + 1) % COUNT;
         end
      end
   endtask

   task automatic compare_all();
      chk("f_valid", int'(f_vld), e_vld);
      chk("h_valid", int'(h_vld), e_vld);
      chk("f_idx", int'(f_idx), e_idx);
      chk("h_idx", int'(h_idx), e_idx);
      chk("f_done", int'(f_fd), e_fd);
      chk("h_done", int'(h_fd), e_fd);
      chk("f_sat", int'(f_sat), 0);
      chk("h_sat", int'(h_sat), e_sat);
      for (int l = 0; l < NUM; l++) begin
         chk($sformatf("f_do1_re%0d", l), int'(f_do1_re[l]), e_f1r[l]);
         chk($sformatf("f_do1_im%0d", l), int'(f_do1_im[l]), e_f1i[l]);
         chk($sformatf("f_do2_re%0d", l), int'(f_do2_re[l]), e_f2r[l]);
         chk($sformatf("f_do2_im%0d", l), int'(f_do2_im[l]), e_f2i[l]);
         chk($sformatf("h_do1_re%0d", l), int'(h_do1_re[l]), e_h1r[l]);
         chk($sformatf("h_do1_im%0d", l), int'(h_do1_im[l]), e_h1i[l]);
         chk($sformatf("h_do2_re%0d", l), int'(h_do2_re[l]), e_h2r[l]);
         chk($sformatf("h_do2_im%0d", l), int'(h_do2_im[l]), e_h2i[l]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      if (f_vld) vld_seen++;
      compare_all();
   endtask

   function automatic logic signed [IN_WIDTH-1:0] small_val();
      int v;
      v = int'($urandom_range(120)) - 60;
      return IN_WIDTH'(v);
   endfunction

   // Lane-0 real carries the directed value; every other component is small noise.
   task automatic drive(input bit v, input bit s, input int re0);
      valid_in = v;
      sync_in  = s;
      din_i[0] = IN_WIDTH'(re0);
      din_q[0] = small_val();
      for (int l = 1; l < NUM; l++) begin
         din_i[l] = small_val();
         din_q[l] = small_val();
      end
      tick();
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      drive(1'b1, 1'b0, 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; sync_in = 1'b0;
      for (int l = 0; l < NUM; l++) begin
         din_i[l] = '0;
         din_q[l] = '0;
      end

      // Reset held 3 cycles under random full-range beats.
      for (int c = 0; c < 3; c++) begin
         valid_in = 1'b1;
         sync_in  = 1'($urandom);
         for (int l = 0; l < NUM; l++) begin
            din_i[l] = IN_WIDTH'($urandom);
            din_q[l] = IN_WIDTH'($urandom);
         end
         tick();
      end
      chk("rst_valid", int'(f_vld), 0);
      chk("rst_do1", int'(f_do1_re[0]), 0);
      rst = 1'b0;

      // Back-to-back frame.
      drive(1, 0, 10);
      chk("post_rst_valid", int'(f_vld), 0);
      drive(1, 0, 20);
      drive(1, 0, 30);
      chk("basic_do1_b2", int'(f_do1_re[0]), 40);
      chk("basic_do2_b2", int'(f_do2_re[0]), -20);
      chk("basic_idx_b2", int'(f_idx), 0);
      drive(1, 0, 40);
      chk("basic_do1_b3", int'(f_do1_re[0]), 60);
      chk("basic_do2_b3", int'(f_do2_re[0]), -20);
      chk("basic_idx_b3", int'(f_idx), 1);
      chk("basic_done_b3", int'(f_fd), 1);

      // Same frame with 3 idle cycles after every beat.
      vld_seen = 0;
      for (int b = 0; b < COUNT; b++) begin
         drive(1, 0, 10 * (b + 1));
         if (b == 2) chk("gap_do1_b2", int'(f_do1_re[0]), 40);
         if (b == 3) chk("gap_do1_b3", int'(f_do1_re[0]), 60);
         for (int g = 0; g < 3; g++) drive(0, 0, 0);
      end
      chk("gap_valid_count", vld_seen, 2);

      // Saturation on the halving instance, sticky into a benign frame.
      reset_cycle();
      chk("sat_clear", int'(h_sat), 0);
      drive(1, 0, 255);
      drive(1, 0, 1);
      drive(1, 0, -256);
      chk("sat_do2", int'(h_do2_re[0]), 255);
      chk("sat_do1", int'(h_do1_re[0]), 0);
      chk("sat_flag_set", int'(h_sat), 1);
      drive(1, 0, 3);
      for (int b = 0; b < COUNT; b++) drive(1, 0, b + 1);
      chk("sat_flag_sticky", int'(h_sat), 1);

      // Sync on the 2nd beat restarts the frame there.
      drive(1, 0, 5);
      drive(1, 1, 11);
      drive(1, 0, 22);
      chk("sync_no_out", int'(f_vld), 0);
      drive(1, 0, 33);
      chk("sync_do1", int'(f_do1_re[0]), 44);
      chk("sync_do2", int'(f_do2_re[0]), -22);
      chk("sync_idx", int'(f_idx), 0);
      drive(1, 0, 44);
      chk("sync_do1_last", int'(f_do1_re[0]), 66);
      chk("sync_done", int'(f_fd), 1);

      // Reset after two beats abandons the frame.
      drive(1, 0, 7);
      drive(1, 0, 8);
      reset_cycle();
      chk("midrst_valid", int'(f_vld), 0);
      drive(1, 0, 1);
      drive(1, 0, 2);
      drive(1, 0, 3);
      chk("midrst_do1", int'(f_do1_re[0]), 4);
      chk("midrst_do2", int'(f_do2_re[0]), -2);
      drive(1, 0, 4);
      chk("midrst_do1_last", int'(f_do1_re[0]), 6);
      chk("midrst_done", int'(f_fd), 1);

      // Random traffic: gaps, syncs, occasional resets, full-range data.
      for (int c = 0; c < 600; c++) begin
         rst      = ($urandom_range(49) == 0);
         valid_in = ($urandom_range(9) < 7);
         sync_in  = ($urandom_range(15) == 0);
         for (int l = 0; l < NUM; l++) begin
            din_i[l] = IN_WIDTH'($urandom);
            din_q[l] = IN_WIDTH'($urandom);
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
